// File: rtl/if_pkg.sv
// Shared opcodes, slot classes and queue entry layout for the fetch queue.
package if_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned ENTRY_PC_W = 32;
  localparam int unsigned NUM_SLOTS  = 3;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;

  // Slot index s corresponds to class value s+1 (R=0, I=1, J=2).
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_R    = 2'd1,
    CLS_I    = 2'd2,
    CLS_J    = 2'd3
  } slot_cls_e;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [ENTRY_PC_W-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/if_slot_classifier.sv
// Maps an opcode to its issue slot class and flags conditional branches.
module if_slot_classifier
  import if_pkg::*;
(
  input  logic [5:0] opcode_i,
  output slot_cls_e  cls_c_o,
  output logic       is_branch_c_o
);

  always_comb begin
    cls_c_o       = CLS_NONE;
    is_branch_c_o = 1'b0;
    case (opcode_i)
      OP_RTYPE, OP_SPECIAL2: cls_c_o = CLS_R;
      OP_J:                  cls_c_o = CLS_J;
      OP_BEQ, OP_BNE: begin
        cls_c_o       = CLS_I;
        is_branch_c_o = 1'b1;
      end
      OP_LW, OP_SW:          cls_c_o = CLS_I;
      default:               cls_c_o = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: two-word fetch into a circular queue, dual issue into R/I/J slots.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned     DEPTH     = 8,
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] FINISH_PC = PC_W'(32'h0000_004C)
) (
  input  logic                        clk,
  input  logic                        btnc_i,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [PC_W-1:0]             redirect_pc,
  output logic [PC_W-1:0]             imem_addr,
  input  logic [31:0]                 imem_word0,
  input  logic [31:0]                 imem_word1,
  output logic [31:0]                 instruction_r,
  output logic [31:0]                 instruction_i,
  output logic [31:0]                 instruction_j,
  output logic [PC_W-1:0]             pc_r,
  output logic [PC_W-1:0]             pc_i,
  output logic [PC_W-1:0]             pc_j,
  output logic                        type_r,
  output logic                        type_i,
  output logic                        type_j,
  output logic [$clog2(DEPTH):0]      q_count,
  output logic                        finish
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               finish_q, finish_d;
  logic [INSTR_W-1:0] slot_instr_q [NUM_SLOTS];
  logic [INSTR_W-1:0] slot_instr_d [NUM_SLOTS];
  logic [PC_W-1:0]    slot_pc_q    [NUM_SLOTS];
  logic [PC_W-1:0]    slot_pc_d    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_vld_q, slot_vld_d;
  fq_entry_t          mem_q [DEPTH];

  logic [CNT_W-1:0] free_c;
  logic             fetch_ok_c, push_two_c, issue_en_c, has_b_c, pair_ok_c;
  logic [1:0]       n_push_c, n_pop_c;
  logic [PTR_W-1:0] head_nx_c;
  fq_entry_t        ent_a_c, ent_b_c;
  slot_cls_e        cls_a_c, cls_b_c;
  logic             br_a_c, br_b_c;

  assign head_nx_c = head_q + PTR_W'(1);
  assign ent_a_c   = mem_q[head_q];
  assign ent_b_c   = mem_q[head_nx_c];

  if_slot_classifier u_cls_a (
    .opcode_i      (ent_a_c.instr[31:26]),
    .cls_c_o       (cls_a_c),
    .is_branch_c_o (br_a_c)
  );

  if_slot_classifier u_cls_b (
    .opcode_i      (ent_b_c.instr[31:26]),
    .cls_c_o       (cls_b_c),
    .is_branch_c_o (br_b_c)
  );

  // Fetch accepts a pair only with room for two, so an aligned fetch never overflows.
  always_comb begin
    free_c     = CNT_W'(DEPTH) - count_q;
    fetch_ok_c = !redirect_valid && (fetch_pc_q != FINISH_PC) && (free_c >= CNT_W'(2));
    push_two_c = fetch_ok_c && !fetch_pc_q[2];
    n_push_c   = fetch_ok_c ? (push_two_c ? 2'd2 : 2'd1) : 2'd0;
  end

  // Pairing rules: structural (class), control (J/branch) and RAW hazards.
  always_comb begin
    issue_en_c = !redirect_valid && !stall && (count_q != '0);
    has_b_c    = count_q >= CNT_W'(2);
    pair_ok_c  = has_b_c && (cls_a_c != CLS_J) && !br_a_c
              && !((cls_a_c == cls_b_c) && (cls_a_c != CLS_NONE))
              && !((cls_a_c == CLS_R) &&
                   ((ent_a_c.instr[15:11] == ent_b_c.instr[25:21]) ||
                    (ent_a_c.instr[15:11] == ent_b_c.instr[20:16])))
              && !((ent_a_c.instr[31:26] == OP_LW) &&
                   ((ent_a_c.instr[20:16] == ent_b_c.instr[25:21]) ||
                    (ent_a_c.instr[20:16] == ent_b_c.instr[20:16])));
    n_pop_c    = issue_en_c ? (pair_ok_c ? 2'd2 : 2'd1) : 2'd0;
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_vld_d   = slot_vld_q;
    finish_d     = finish_q | ((fetch_pc_q == FINISH_PC) && (count_q == '0) && (slot_vld_q == '0));

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        slot_instr_d[s] = '0;
        slot_pc_d[s]    = '0;
      end
      slot_vld_d = '0;
    end else begin
      if (fetch_ok_c) begin
        fetch_pc_d = fetch_pc_q + (push_two_c ? PC_W'(8) : PC_W'(4));
      end
      tail_d  = tail_q + PTR_W'(n_push_c);
      head_d  = head_q + PTR_W'(n_pop_c);
      count_d = count_q + CNT_W'(n_push_c) - CNT_W'(n_pop_c);
      // Unstalled slots reload every cycle; anything not issued this cycle clears.
      if (!stall) begin
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
          slot_instr_d[s] = '0;
          slot_pc_d[s]    = '0;
          slot_vld_d[s]   = 1'b0;
          if (issue_en_c && (cls_a_c == slot_cls_e'(2'(s + 1)))) begin
            slot_instr_d[s] = ent_a_c.instr;
            slot_pc_d[s]    = PC_W'(ent_a_c.pc);
            slot_vld_d[s]   = 1'b1;
          end else if (issue_en_c && pair_ok_c && (cls_b_c == slot_cls_e'(2'(s + 1)))) begin
            slot_instr_d[s] = ent_b_c.instr;
            slot_pc_d[s]    = PC_W'(ent_b_c.pc);
            slot_vld_d[s]   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge btnc_i) begin
    if (!btnc_i) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      finish_q   <= 1'b0;
      slot_vld_q <= '0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        slot_instr_q[s] <= '0;
        slot_pc_q[s]    <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      finish_q     <= finish_d;
      slot_vld_q   <= slot_vld_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (fetch_ok_c) begin
      mem_q[tail_q] <= '{instr: imem_word0, pc: ENTRY_PC_W'(fetch_pc_q)};
      if (push_two_c) begin
        mem_q[tail_q + PTR_W'(1)] <= '{instr: imem_word1, pc: ENTRY_PC_W'(fetch_pc_q + PC_W'(4))};
      end
    end
  end

  assign imem_addr     = fetch_pc_q;
  assign instruction_r = slot_instr_q[0];
  assign instruction_i = slot_instr_q[1];
  assign instruction_j = slot_instr_q[2];
  assign pc_r          = slot_pc_q[0];
  assign pc_i          = slot_pc_q[1];
  assign pc_j          = slot_pc_q[2];
  assign type_r        = slot_vld_q[0];
  assign type_i        = slot_vld_q[1];
  assign type_j        = slot_vld_q[2];
  assign q_count       = count_q;
  assign finish        = finish_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a combinational instruction memory model.
module tb_if_fetch_queue;

  localparam logic [31:0] ADD  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] LW4  = 32'h8CA4_0000; // lw  $4,0($5)
  localparam logic [31:0] SUB  = 32'h0061_3022; // sub $6,$3,$1
  localparam logic [31:0] BEQ  = 32'h1022_0004; // beq $1,$2,+4
  localparam logic [31:0] LW7  = 32'h8D07_0000; // lw  $7,0($8)
  localparam logic [31:0] NONE = 32'h2001_0001; // addi: no slot

  logic        clk = 1'b0;
  logic        btnc_i = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_word0, imem_word1;
  logic [31:0] instruction_r, instruction_i, instruction_j;
  logic [31:0] pc_r, pc_i, pc_j;
  logic        type_r, type_i, type_j;
  logic [3:0]  q_count;
  logic        finish;

  logic [31:0] imem [0:31];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_word0 = imem[imem_addr[6:2]];
  assign imem_word1 = imem[imem_addr[6:2] + 5'd1];

  if_fetch_queue dut (
    .clk            (clk),
    .btnc_i         (btnc_i),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_word0     (imem_word0),
    .imem_word1     (imem_word1),
    .instruction_r  (instruction_r),
    .instruction_i  (instruction_i),
    .instruction_j  (instruction_j),
    .pc_r           (pc_r),
    .pc_i           (pc_i),
    .pc_j           (pc_j),
    .type_r         (type_r),
    .type_i         (type_i),
    .type_j         (type_j),
    .q_count        (q_count),
    .finish         (finish)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic fill_none();
    for (int k = 0; k < 32; k++) imem[k] = NONE;
  endtask

  // Leaves the bench at a negedge with reset released; next posedge is edge 1.
  task automatic do_reset();
    btnc_i = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    btnc_i = 1'b1;
  endtask

  initial begin
    // Reset state and aligned dual issue
    fill_none();
    imem[0] = ADD;
    imem[1] = LW4;
    @(negedge clk);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_types", {29'd0, type_r, type_i, type_j}, 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    do_reset();
    tick(1);
    chk("p1_e1_q_count", 32'(q_count), 32'd2);
    chk("p1_e1_type_r", 32'(type_r), 32'd0);
    tick(1);
    chk("p1_e2_type_r", 32'(type_r), 32'd1);
    chk("p1_e2_type_i", 32'(type_i), 32'd1);
    chk("p1_e2_pc_r", pc_r, 32'h0);
    chk("p1_e2_pc_i", pc_i, 32'h4);
    chk("p1_e2_instr_i", instruction_i, LW4);
    chk("p1_e2_imem_addr", imem_addr, 32'd16);

    // RAW-dependent R pair splits
    fill_none();
    imem[0] = ADD;
    imem[1] = SUB;
    do_reset();
    tick(2);
    chk("p2_e2_instr_r", instruction_r, ADD);
    chk("p2_e2_type_i", 32'(type_i), 32'd0);
    chk("p2_e2_q_count", 32'(q_count), 32'd3);
    tick(1);
    chk("p2_e3_instr_r", instruction_r, SUB);
    chk("p2_e3_pc_r", pc_r, 32'h4);
    chk("p2_e3_type_r", 32'(type_r), 32'd1);

    // Branch never pairs with a follower
    fill_none();
    imem[2] = BEQ;
    imem[3] = LW7;
    do_reset();
    tick(2);
    chk("p3_e2_types", {29'd0, type_r, type_i, type_j}, 32'd0);
    tick(1);
    chk("p3_e3_instr_i", instruction_i, BEQ);
    chk("p3_e3_pc_i", pc_i, 32'h8);
    chk("p3_e3_q_count", 32'(q_count), 32'd3);
    tick(1);
    chk("p3_e4_instr_i", instruction_i, LW7);
    chk("p3_e4_pc_i", pc_i, 32'hC);

    // Stall saturation, drain, redirect to an unaligned target
    fill_none();
    imem[0] = ADD;
    imem[1] = LW4;
    imem[9] = SUB;
    do_reset();
    tick(2);
    stall = 1'b1;
    tick(6);
    chk("p4_stall_q_count", 32'(q_count), 32'd8);
    chk("p4_stall_imem_addr", imem_addr, 32'd40);
    chk("p4_stall_pc_r", pc_r, 32'h0);
    chk("p4_stall_instr_i", instruction_i, LW4);
    chk("p4_stall_type_i", 32'(type_i), 32'd1);
    stall = 1'b0;
    tick(1);
    chk("p4_drain_q_count", 32'(q_count), 32'd6);
    chk("p4_drain_type_r", 32'(type_r), 32'd0);
    chk("p4_drain_imem_addr", imem_addr, 32'd40);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h24;
    tick(1);
    chk("p4_redir_q_count", 32'(q_count), 32'd0);
    chk("p4_redir_imem_addr", imem_addr, 32'h24);
    redirect_valid = 1'b0;
    stall = 1'b0;
    tick(1);
    chk("p4_single_q_count", 32'(q_count), 32'd1);
    chk("p4_single_imem_addr", imem_addr, 32'h28);
    tick(1);
    chk("p4_single_instr_r", instruction_r, SUB);
    chk("p4_single_pc_r", pc_r, 32'h24);
    chk("p4_single_type_r", 32'(type_r), 32'd1);
    chk("p4_after_q_count", 32'(q_count), 32'd2);

    // Finish detect, stickiness and asynchronous reset
    redirect_valid = 1'b1;
    redirect_pc = 32'h4C;
    tick(1);
    redirect_valid = 1'b0;
    chk("p5_redir_types", {29'd0, type_r, type_i, type_j}, 32'd0);
    chk("p5_redir_finish", 32'(finish), 32'd0);
    tick(1);
    chk("p5_finish_set", 32'(finish), 32'd1);
    chk("p5_halt_imem_addr", imem_addr, 32'h4C);
    chk("p5_halt_q_count", 32'(q_count), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    chk("p5_sticky_finish", 32'(finish), 32'd1);
    chk("p5_refetch_q_count", 32'(q_count), 32'd2);
    chk("p5_refetch_imem_addr", imem_addr, 32'h18);
    #2;
    btnc_i = 1'b0;
    #1;
    chk("p5_async_finish", 32'(finish), 32'd0);
    chk("p5_async_q_count", 32'(q_count), 32'd0);
    chk("p5_async_imem_addr", imem_addr, 32'h0);
    tick(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the dual-issue IF stage: decouples instruction-memory fetch from slot issue through a circular instruction queue.
- Fetches up to two words per cycle into a DEPTH-entry queue.
- Issues up to two instructions per cycle into R/I/J slot registers using the team's pairing rules.
- Supports stall, redirect-flush, unaligned redirect targets and a finish detect; sits between instruction_memory and the ID stage.

Parameters:
- DEPTH, 8, queue entries; power of two, >=4.
- PC_W, 32, program counter width.
- RESET_PC, 0, fetch PC after reset.
- FINISH_PC, 32'h0000004C, address at which fetch halts.

Ports:
- clk  in  1  system clock.
- btnc_i  in  1  asynchronous active-low reset.
- stall  in  1  ID hazard; freezes issue and slot outputs.
- redirect_valid  in  1  taken branch or jump resolved downstream.
- redirect_pc  in  PC_W  redirect target, word aligned.
- imem_addr  out  PC_W  fetch address; equals fetch_pc.
- imem_word0  in  32  combinational read at imem_addr.
- imem_word1  in  32  combinational read at imem_addr+4.
- instruction_r / instruction_i / instruction_j  out  32 each  slot instructions.
- pc_r / pc_i / pc_j  out  PC_W each  slot instruction addresses.
- type_r / type_i / type_j  out  1 each  slot valid.
- q_count  out  $clog2(DEPTH)+1  queue occupancy.
- finish  out  1  program done, sticky.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on btnc_i.
- Reset values: fetch_pc=RESET_PC, head=tail=0, q_count=0, all slot instruction/pc outputs 0, all type_* 0, finish 0.
- Queue entry: {instr[31:0], pc[PC_W-1:0]}. head/tail wrap modulo DEPTH. Separate count register; no full/empty ambiguity.
- Fetch, one cycle per push:
  - Push only when !redirect_valid, fetch_pc!=FINISH_PC and free>=2.
  - fetch_pc[2]==0: push word0 then word1; fetch_pc+=8.
  - fetch_pc[2]==1 (unaligned after redirect): push word0 only; fetch_pc+=4.
  - free<2: no push, fetch_pc held.
- Classification by opcode [31:26]:
  - R: 000000, 011100.
  - J: 000010.
  - I: 000100, 000101, 100011, 101011.
  - Anything else is NONE.
  - BR = opcode 000100 or 000101.
- Issue, when !stall and q_count>=1: head entry A, next entry B (if q_count>=2).
- Pairing is refused when any of the following hold:
  - no B;
  - A is J or BR;
  - class(A)==class(B) and class is not NONE;
  - A is R and A[15:11] equals B[25:21] or B[20:16];
  - A is 100011 and A[20:16] equals B[25:21] or B[20:16].
- Pop: 2 if paired, else 1.
- Each popped R/I/J instruction loads its slot register (instruction, pc, type=1) on the clock edge. Latency is one cycle from queue head to slot output.
- Slots receiving nothing load type=0, instruction=0, pc=0.
- A NONE entry is popped and dropped; it occupies no slot.
- Stall: slots and queue head hold; fetch continues while space allows.
- Redirect, highest priority, same edge:
  - queue flushed (head=tail=0, count=0);
  - all slots cleared to type=0;
  - fetch_pc <= redirect_pc;
  - no push and no pop that cycle;
  - overrides stall.
- Push and pop in the same cycle are allowed: count_next = count + pushed - popped. Issue of the last entry while a push lands is legal.
- finish: set on the edge where fetch_pc==FINISH_PC, q_count==0 and all type_* are 0. Remains 1 until reset; a redirect does not clear it.
- Reset mid-operation: immediate return to reset values, independent of clk.

Decomposition:
- Package if_pkg:
  - opcode localparams (OP_RTYPE, OP_SPECIAL2, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW);
  - slot class enum {CLS_NONE, CLS_R, CLS_I, CLS_J};
  - entry struct.
- Sub-module if_slot_classifier: combinational opcode -> class plus is_branch. Instantiated twice (A and B).
- Queue storage, pointers and pairing logic stay in if_fetch_queue.

Test Plan:
- Reset, then aligned stream (imem returns add $3,$1,$2 and lw $4,0($5)) -> first push at cycle 1, q_count=2. Next edge: type_r=1, type_i=1, pc_r=0, pc_i=4; fetch_pc=16 after two edges.
- R then dependent R (add $3,.. ; sub $6,$3,$1) -> only add issues; sub issues alone next cycle with pc_r=4.
- beq at pc 8 paired with following lw -> beq issues alone in type_i; lw issues the next cycle.
- Hold stall for 6 cycles with DEPTH=8 -> q_count saturates at 8 (fetch stops at free<2), slots unchanged, fetch_pc frozen. Release stall -> drain resumes.
- redirect_valid with redirect_pc=0x24 while stalled and q_count=6 -> next edge: q_count=0, all type_*=0, imem_addr=0x24. Next push is a single word (pc 0x24); the following fetch is at 0x28.
- Run until fetch_pc=0x4C -> fetch stops, queue drains, finish=1 one edge after the last slot clears. Assert btnc_i=0 mid-cycle -> finish and all outputs drop without a clock edge.
